// File: rtl/display_console.sv
// Eight-digit multiplexed hex display with a debounced resume button for a CPU.
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the highest nonzero nibble.
module display_console #(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        CLR,
  input  logic [31:0] display,
  input  logic        halt,
  input  logic        btn_go,
  output logic        GO,
  output logic [7:0]  an,
  output logic [7:0]  seg
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned CNT_W = $clog2(DEB_CYCLES);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [7:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;
  logic             tick;
  logic [3:0]       nib;
  logic [6:0]       seg7;

  logic [1:0]       sync_q;
  logic             deb_q, deb_d;
  logic             deb_dly_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             go_q, go_d;

`ifdef LEADING_ZERO_BLANK_EN
  logic [2:0]       msd;
`endif

  // Outputs are decoded from the next-state index/shadow so they land one cycle after the tick.
  always_comb begin
    tick     = (div_q == DIV_LAST);
    div_d    = tick ? '0 : div_q + 1'b1;
    idx_d    = tick ? idx_q + 3'd1 : idx_q;
    shadow_d = (tick && idx_q == 3'd7) ? display : shadow_q;
    nib      = shadow_d[{idx_d, 2'b00} +: 4];
    case (nib)
      4'h0:    seg7 = 7'h40;
      4'h1:    seg7 = 7'h79;
      4'h2:    seg7 = 7'h24;
      4'h3:    seg7 = 7'h30;
      4'h4:    seg7 = 7'h19;
      4'h5:    seg7 = 7'h12;
      4'h6:    seg7 = 7'h02;
      4'h7:    seg7 = 7'h78;
      4'h8:    seg7 = 7'h00;
      4'h9:    seg7 = 7'h10;
      4'hA:    seg7 = 7'h08;
      4'hB:    seg7 = 7'h03;
      4'hC:    seg7 = 7'h46;
      4'hD:    seg7 = 7'h21;
      4'hE:    seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    msd = '0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (shadow_d[4*i +: 4] != 4'h0) msd = 3'(i);
    end
    if (idx_d > msd) seg7 = 7'h7F;
`endif
    an_d  = ~(8'd1 << idx_d);
    seg_d = {~((idx_d == 3'd0) && halt), seg7};
  end

  // A count only survives while the synchronized input keeps differing from the accepted state.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync_q[1] != deb_q) begin
      if (cnt_q == CNT_LAST) deb_d = sync_q[1];
      else                   cnt_d = cnt_q + 1'b1;
    end
    go_d = deb_q & ~deb_dly_q;
  end

  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      div_q     <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      an_q      <= '1;
      seg_q     <= '1;
      sync_q    <= '0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
      cnt_q     <= '0;
      go_q      <= 1'b0;
    end else begin
      div_q     <= div_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      sync_q    <= {sync_q[0], btn_go};
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      cnt_q     <= cnt_d;
      go_q      <= go_d;
    end
  end

  assign GO  = go_q;
  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_display_console.sv
// Bench for display_console: frame scoreboard for the scan path, hand sequences for debounce and reset.
module tb_display_console;

  localparam int unsigned SD = 4;
  localparam int unsigned DC = 3;

  logic        clk = 1'b0;
  logic        CLR;
  logic [31:0] display;
  logic        halt;
  logic        btn_go;
  logic        GO;
  logic [7:0]  an;
  logic [7:0]  seg;

  display_console #(.SCAN_DIV(SD), .DEB_CYCLES(DC)) dut (
    .clk(clk), .CLR(CLR), .display(display), .halt(halt),
    .btn_go(btn_go), .GO(GO), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed { logic [7:0] an; logic [7:0] seg; } exp_t;
  typedef struct {
    logic [31:0]     disp;
    logic            hlt;
    int unsigned     off;
    logic [7:0][6:0] s7;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[7];
  bit   sb_en = 1'b0;
  int   cyc = 0;
  int   go_cnt = 0;
  logic [7:0] prev_an = 8'hFF;
  logic h_s;

  function automatic vec_t mk(input logic [31:0] d, input logic h, input int unsigned off,
                              input logic [55:0] s);
    vec_t v;
    v.disp = d; v.hlt = h; v.off = off; v.s7 = s;
    return v;
  endfunction

  task automatic push_frame(input vec_t v);
    exp_t e;
    for (int d = 0; d < 8; d++) begin
      e.an  = ~(8'd1 << d);
      e.seg = {~((d == 0) && v.hlt), v.s7[d]};
      sbq.push_back(e);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Scan monitor: pops one expected slot each time the active digit changes.
  always @(posedge clk) begin
    h_s = halt;
    #1;
    if (!CLR) begin
      cyc = 0;
      prev_an = 8'hFF;
    end else begin
      cyc++;
      if (GO === 1'b1) go_cnt++;
      if (sb_en) begin
        chk("dp", {31'b0, seg[7]}, {31'b0, ~((an == 8'hFE) && h_s)});
        if (an !== prev_an) begin
          if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_pop: digit change to an=%h with no expected entry", an);
          end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("scan_an", an, e.an);
            chk("scan_seg", seg, e.seg);
          end
        end
      end
      prev_an = an;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seg_d4;
`ifdef LEADING_ZERO_BLANK_EN
    vecs[0] = mk(32'h0, 1'b0, 0, {{7{7'h7F}}, 7'h40});
    vecs[5] = mk(32'h0000_00A0, 1'b0, 4, {{6{7'h7F}}, 7'h08, 7'h40});
    vecs[6] = mk(32'h0, 1'b0, 4, {{7{7'h7F}}, 7'h40});
    seg_d4  = 8'hFF;
`else
    vecs[0] = mk(32'h0, 1'b0, 0, {8{7'h40}});
    vecs[5] = mk(32'h0000_00A0, 1'b0, 4, {{6{7'h40}}, 7'h08, 7'h40});
    vecs[6] = mk(32'h0, 1'b0, 4, {8{7'h40}});
    seg_d4  = 8'hC0;
`endif
    vecs[1] = mk(32'h1234_ABCD, 1'b0, 4,
                 {7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21});
    vecs[2] = vecs[1];
    vecs[3] = mk(32'hFFFF_FFFF, 1'b0, 20, {8{7'h0E}});
    vecs[4] = mk(32'hFFFF_FFFF, 1'b1, 4, {8{7'h0E}});

    CLR = 1'b1; display = 32'h1234_ABCD; halt = 1'b0; btn_go = 1'b0;
    #2 CLR = 1'b0;
    #1;
    chk("rst_an", an, 8'hFF);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_go", GO, 0);
    repeat (2) @(negedge clk);
    push_frame(vecs[0]);
    sb_en = 1'b1;
    CLR = 1'b1;

    // Vector 3 is applied mid-frame, so the frame still showing 1234ABCD must be unaffected.
    for (int i = 1; i < 7; i++) begin
      wait_cyc(32 * i - int'(vecs[i].off));
      display = vecs[i].disp;
      halt    = vecs[i].hlt;
      push_frame(vecs[i]);
    end
    for (int t = 0; t < 64 && sbq.size() != 0; t++) @(negedge clk);
    chk("sb_drain", sbq.size(), 0);
    sb_en = 1'b0;
    chk("go_idle", go_cnt, 0);

    halt = 1'b1;
    @(negedge clk) btn_go = 1'b1;
    @(negedge clk) btn_go = 1'b0;
    @(negedge clk) btn_go = 1'b1;
    @(negedge clk) btn_go = 1'b0;
    @(negedge clk) btn_go = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      chk($sformatf("go_press%0d", k), GO, (k == 6));
    end
    @(negedge clk) btn_go = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      chk($sformatf("go_release%0d", k), GO, 0);
    end
    chk("go_total", go_cnt, 1);

    halt = 1'b0;
    display = 32'h89AB_CDEF;
    @(negedge clk) btn_go = 1'b1;
    repeat (3) @(negedge clk);
    #2 CLR = 1'b0;
    #1;
    chk("midrst_an", an, 8'hFF);
    chk("midrst_seg", seg, 8'hFF);
    chk("midrst_go", GO, 0);
    btn_go = 1'b0;
    repeat (2) @(negedge clk);
    CLR = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        chk("restart_an", an, 8'hFE);
        chk("restart_seg", seg, 8'hC0);
      end
      if (k == 3) chk("restart_an3", an, 8'hFE);
      if (k == 4) begin
        chk("restart_an4", an, 8'hFD);
        chk("restart_seg4", seg, seg_d4);
      end
      chk($sformatf("restart_go%0d", k), GO, 0);
    end
    chk("go_after_rst", go_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
